m_memarb: RTL
=============

Name: m_memarb

Overview:
- Two-requester arbiter that shares one single-port synchronous word memory (m_memory-style: 1-cycle registered read, write at posedge) between the IF-stage fetch port and the MEM-stage load/store port.
- Lets a unified instruction/data RAM replace the split imem/dmem pair.
- Data side has fixed priority. A starvation counter guarantees fetch progress.
- Tracks the in-flight read and steers returned data to the requester that issued it.

Parameters:
- ADDR_W, 12, word-address width (4K words)
- DATA_W, 32, data width
- STARVE_MAX, 4, max consecutive cycles fetch may be refused while requesting before it is force-granted (legal range 1..255)

Ports:
- w_clk  in  1  clock, all state on posedge
- w_rst_n  in  1  asynchronous active-low reset
- w_ireq  in  1  fetch read request
- w_iaddr  in  ADDR_W  fetch word address
- w_igrant  out  1  fetch request accepted this cycle (combinational)
- r_ivalid  out  1  fetch read data valid (registered)
- w_idata  out  DATA_W  fetch read data
- w_dreq  in  1  data request
- w_dwe  in  1  data write enable (qualifies w_dreq)
- w_daddr  in  ADDR_W  data word address
- w_dwdata  in  DATA_W  store data
- w_dgrant  out  1  data request accepted this cycle (combinational)
- r_dvalid  out  1  load data valid (registered)
- w_ddata  out  DATA_W  load data
- w_maddr  out  ADDR_W  memory address
- w_mwe  out  1  memory write enable
- w_mdin  out  DATA_W  memory write data
- w_mdout  in  DATA_W  memory read data, valid the cycle after the address
- r_istall_cnt  out  32  fetch-refused cycle count
- r_dstall_cnt  out  32  data-refused cycle count

Behaviour:
- Reset (w_rst_n=0, async): r_ivalid=0, r_dvalid=0, r_starve=0, r_pend=NONE, state=ST_DPRI, stall counters=0. While reset is held, w_igrant=w_dgrant=w_mwe=0.
- Reset mid-read: the pending read is dropped. No valid pulse follows reset release.
- FSM states:
  - ST_DPRI (data priority): w_dgrant=w_dreq; w_igrant=w_ireq & ~w_dreq.
  - ST_IFORCE: w_igrant=w_ireq; w_dgrant=w_dreq & ~w_ireq.
- r_starve:
  - cleared when w_igrant=1 or w_ireq=0.
  - incremented when w_ireq & ~w_igrant.
- Transitions:
  - ST_DPRI -> ST_IFORCE when w_ireq & ~w_igrant & r_starve==STARVE_MAX-1.
  - ST_IFORCE -> ST_DPRI on the next cycle with w_igrant=1, or on the next cycle w_ireq=0.
- Memory drive: granted requester's address. w_mwe=w_dgrant & w_dwe; w_mdin=w_dwdata. With no grant, w_maddr=w_iaddr and w_mwe=0.
- Read steering:
  - r_pend <= I if fetch granted; D if data granted with w_dwe=0; NONE otherwise (including writes).
  - r_ivalid=(r_pend==I); r_dvalid=(r_pend==D). Latency is exactly 1 cycle grant->valid.
  - w_idata=w_ddata=w_mdout. Requesters qualify with valid.
- At most one grant per cycle. Back-to-back grants to either side are legal every cycle (full throughput).
- A requester keeps req, address and write data stable until granted. A refused request is not queued inside the block.
- Simultaneous data write and pending fetch read to the same address: the fetch granted earlier sees the old word (read-before-write, as m_memory).
- STARVE_MAX=1: fetch is force-granted after a single refused cycle, i.e. strict alternation under contention.

Optional Feature:
- MEMARB_STATS_EN defined:
  - r_istall_cnt increments on w_ireq & ~w_igrant.
  - r_dstall_cnt increments on w_dreq & ~w_dgrant.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Not defined: both ports are constant 0 and no counter flops are built.

Decomposition:
- Shared package/header: state encodings ST_DPRI/ST_IFORCE, pending-source encodings PEND_NONE/PEND_I/PEND_D, default ADDR_W/DATA_W.
- One natural sub-module, m_memarb_sel: purely combinational grant/select logic (state, reqs -> grants, maddr, mwe).
- FSM, starvation counter, pending tracker and stats stay in m_memarb.

Test Plan:
- Fetch only: w_ireq=1, w_iaddr=0..4 each cycle over RAM preloaded with word k=k*3 -> w_igrant=1 each cycle; r_ivalid one cycle later with w_idata=0,3,6,9,12.
- Data store then load: dreq/dwe=1, w_daddr=0x20, w_dwdata=0xDEADBEEF; next cycle load from 0x20 -> r_dvalid=1 with 0xDEADBEEF two cycles after the store; no r_dvalid after the store cycle.
- Contention, STARVE_MAX=4: w_ireq and w_dreq held high continuously -> grant pattern D,D,D,D,I repeating; max 4 consecutive fetch refusals.
- Read steering: fetch read at 0x1 then data read at 0x2 on consecutive cycles -> r_ivalid then r_dvalid on consecutive cycles with the correct words; never both high.
- Reset mid-read: assert w_rst_n=0 asynchronously between grant and data return -> r_ivalid/r_dvalid stay 0, grants 0 during reset; after release r_starve=0 and state=ST_DPRI.
- MEMARB_STATS_EN: 10 contended cycles with STARVE_MAX=4 -> r_istall_cnt=8, r_dstall_cnt=2; without the macro both read 0.

Source files
------------

// File: rtl/m_memarb_pkg.sv
// m_memarb_pkg: shared encodings and default widths for the fetch/data memory arbiter.
package m_memarb_pkg;
   localparam int MEMARB_ADDR_W = 12;
   localparam int MEMARB_DATA_W = 32;
   typedef enum logic {ST_DPRI, ST_IFORCE} state_e;
   typedef enum logic [1:0] {PEND_NONE, PEND_I, PEND_D} pend_e;
endpackage

// File: rtl/m_memarb_if.sv
// m_memarb_if: fetch port, data port, memory port and stall counters of the arbiter.
interface m_memarb_if import m_memarb_pkg::*; #(
   parameter int ADDR_W = MEMARB_ADDR_W,
   parameter int DATA_W = MEMARB_DATA_W
);
   logic              w_ireq;
   logic [ADDR_W-1:0] w_iaddr;
   logic              w_igrant;
   logic              r_ivalid;
   logic [DATA_W-1:0] w_idata;
   logic              w_dreq;
   logic              w_dwe;
   logic [ADDR_W-1:0] w_daddr;
   logic [DATA_W-1:0] w_dwdata;
   logic              w_dgrant;
   logic              r_dvalid;
   logic [DATA_W-1:0] w_ddata;
   logic [ADDR_W-1:0] w_maddr;
   logic              w_mwe;
   logic [DATA_W-1:0] w_mdin;
   logic [DATA_W-1:0] w_mdout;
   logic [31:0]       r_istall_cnt;
   logic [31:0]       r_dstall_cnt;
   modport slave (
      input  w_ireq, w_iaddr, w_dreq, w_dwe, w_daddr, w_dwdata, w_mdout,
      output w_igrant, r_ivalid, w_idata, w_dgrant, r_dvalid, w_ddata,
             w_maddr, w_mwe, w_mdin, r_istall_cnt, r_dstall_cnt
   );
   modport master (
      output w_ireq, w_iaddr, w_dreq, w_dwe, w_daddr, w_dwdata, w_mdout,
      input  w_igrant, r_ivalid, w_idata, w_dgrant, r_dvalid, w_ddata,
             w_maddr, w_mwe, w_mdin, r_istall_cnt, r_dstall_cnt
   );
endinterface

// File: rtl/m_memarb_sel.sv
// m_memarb_sel: combinational grant and memory-port select; en_i low blocks every grant.
module m_memarb_sel import m_memarb_pkg::*; #(
   parameter int ADDR_W = MEMARB_ADDR_W
) (
   input  state_e            state_i,
   input  logic              en_i,
   input  logic              ireq_i,
   input  logic              dreq_i,
   input  logic              dwe_i,
   input  logic [ADDR_W-1:0] iaddr_i,
   input  logic [ADDR_W-1:0] daddr_i,
   output logic              igrant_o,
   output logic              dgrant_o,
   output logic              mwe_o,
   output logic [ADDR_W-1:0] maddr_o
);
   assign igrant_o = en_i & ireq_i & ((state_i == ST_IFORCE) | ~dreq_i);
   assign dgrant_o = en_i & dreq_i & ((state_i == ST_DPRI) | ~ireq_i);
   assign mwe_o    = dgrant_o & dwe_i;
   assign maddr_o  = dgrant_o ? daddr_i : iaddr_i;
endmodule

// File: rtl/m_memarb.sv
// m_memarb: fixed data-priority arbiter with fetch anti-starvation over one synchronous RAM.
// Optional stall counters are built only when MEMARB_STATS_EN is defined.
module m_memarb import m_memarb_pkg::*; #(
   parameter int ADDR_W     = MEMARB_ADDR_W,
   parameter int DATA_W     = MEMARB_DATA_W,
   parameter int STARVE_MAX = 4
) (
   input logic        w_clk,
   input logic        w_rst_n,
   m_memarb_if.slave  bus
);
   state_e            state_q, state_d;
   pend_e             pend_q, pend_d;
   logic [7:0]        starve_q, starve_d;
   logic              igrant, dgrant;
   logic              i_refused;
   logic [DATA_W-1:0] rdata;
   m_memarb_sel #(.ADDR_W(ADDR_W)) u_sel (
      .state_i  (state_q),
      .en_i     (w_rst_n),
      .ireq_i   (bus.w_ireq),
      .dreq_i   (bus.w_dreq),
      .dwe_i    (bus.w_dwe),
      .iaddr_i  (bus.w_iaddr),
      .daddr_i  (bus.w_daddr),
      .igrant_o (igrant),
      .dgrant_o (dgrant),
      .mwe_o    (bus.w_mwe),
      .maddr_o  (bus.w_maddr)
   );
   assign i_refused = bus.w_ireq & ~igrant;
   // IFORCE always resolves in one cycle: fetch is either granted or no longer asking
   always_comb begin
      starve_d = i_refused ? starve_q + 8'd1 : 8'd0;
      state_d  = (state_q == ST_DPRI)
               ? ((i_refused && starve_q == 8'(STARVE_MAX - 1)) ? ST_IFORCE : ST_DPRI)
               : (i_refused ? ST_IFORCE : ST_DPRI);
      pend_d   = igrant ? PEND_I : (dgrant & ~bus.w_dwe) ? PEND_D : PEND_NONE;
   end
   always_ff @(posedge w_clk or negedge w_rst_n)
      if (!w_rst_n) begin
         state_q  <= ST_DPRI;
         starve_q <= '0;
         pend_q   <= PEND_NONE;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         pend_q   <= pend_d;
      end
   assign rdata        = bus.w_mdout;
   assign bus.w_idata  = rdata;
   assign bus.w_ddata  = rdata;
   assign bus.r_ivalid = (pend_q == PEND_I);
   assign bus.r_dvalid = (pend_q == PEND_D);
   assign bus.w_igrant = igrant;
   assign bus.w_dgrant = dgrant;
   assign bus.w_mdin   = bus.w_dwdata;
`ifdef MEMARB_STATS_EN
   logic [31:0] istall_q, dstall_q;
   always_ff @(posedge w_clk or negedge w_rst_n)
      if (!w_rst_n) begin
         istall_q <= '0;
         dstall_q <= '0;
      end else begin
         if (i_refused && !(&istall_q)) istall_q <= istall_q + 32'd1;
         if (bus.w_dreq && !dgrant && !(&dstall_q)) dstall_q <= dstall_q + 32'd1;
      end
   assign bus.r_istall_cnt = istall_q;
   assign bus.r_dstall_cnt = dstall_q;
`else
   assign bus.r_istall_cnt = '0;
   assign bus.r_dstall_cnt = '0;
`endif
endmodule
